tx_bus_arbiter: RTL
===================

# tx_bus_arbiter

Shares the single serial TX/RX memory channel between the data-access unit (loads/stores) and the instruction prefetcher. It arbitrates command issue, forwards the start/done handshakes, and steers returning RX payload to the requester that issued the read. It tracks issue order in a small tag FIFO. It sits between the two requesters and the TX serializer / RX deserializer.

## Interface
- CMD_BITS, 2: width of a TX command header.
- MAX_OUTSTANDING, 2: maximum number of issued reads whose response has not yet completed.
- STARVE_LIMIT, 3: number of consecutive data grants allowed while the prefetcher waits; must be ≥1.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- d_cmd_valid  in  1  data unit requests a command.
- d_cmd  in  CMD_BITS  data unit command header.
- d_expect_resp  in  1  the data command produces an RX response (read).
- d_cmd_started  out  1  pulse: the data command was accepted by TX.
- d_rx_data_valid, d_rx_done  out  1  RX payload strobe / completion, steered to the data unit.
- p_cmd_valid  in  1  prefetcher request; always a read.
- p_cmd  in  CMD_BITS  prefetcher command header.
- p_cmd_started  out  1  pulse: the prefetch command was accepted.
- p_rx_data_valid, p_rx_done  out  1  RX strobe / completion, steered to the prefetcher.
- tx_command_valid  out  1  command offered to the TX serializer.
- tx_command  out  CMD_BITS  selected header.
- tx_command_started  in  1  TX accepted the offered command this cycle.
- tx_done  in  1  TX finished the current transaction.
- rx_data_valid, rx_done  in  1  payload strobe / completion from RX.
- owner  out  1  0 = data, 1 = prefetch; owner of the current or last TX transaction. The payload mux select for tx_data.
- err_unsolicited  out  1  sticky flag: rx_done arrived while no response was pending.

## Operation
- FSM states:
  - IDLE: a command may be offered.
  - BUSY: a TX transaction is in flight, from tx_command_started to tx_done.
- IDLE → BUSY on tx_command_started. BUSY → IDLE on tx_done.
- If tx_command_started and tx_done occur together, the state goes to BUSY (a new start wins).
- Offer condition: tx_command_valid = IDLE && (d_cmd_valid || p_cmd_valid) && !fifo_full.
  - fifo_full blocks both requesters, including data writes, so that issue order stays simple.
- Selection (combinational, in IDLE):
  - Data wins by default.
  - The prefetcher wins if d_cmd_valid is low, or if starve_cnt == STARVE_LIMIT.
- tx_command is the selected requester's header. The selection is frozen as owner on tx_command_started.
- The started pulse is forwarded combinationally to the selected requester only.
- starve_cnt (width clog2(STARVE_LIMIT+1)) updates on each start:
  - data grant while p_cmd_valid is high: increment, saturating at STARVE_LIMIT;
  - prefetch grant, or data grant with p_cmd_valid low: clear to 0.
- Tag FIFO:
  - Depth MAX_OUTSTANDING, 1-bit entries (0 = data, 1 = prefetch).
  - Push on a start with an expected response: d_expect_resp for data, always for prefetch.
  - Pop on rx_done.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Pop with the FIFO empty: no pop, and err_unsolicited is set.
- RX steering by head tag:
  - d_rx_* = rx_* && !empty && head==0.
  - p_rx_* = rx_* && !empty && head==1.
  - With the FIFO empty, no RX outputs are asserted.
- Requesters must hold cmd_valid and cmd stable until their started pulse. The arbiter does not check this.

## Timing
- Reset values:
  - state IDLE; FIFO empty; starve_cnt 0; owner 0; err_unsolicited 0.
  - All *_started and *_rx_* outputs are 0.
  - tx_command_valid is 0 unless a request is present.
- Command offer: zero latency. tx_command_valid rises in the same cycle the request appears in IDLE.
- Started forwarding, tx_command_started to d/p_cmd_started: 0 cycles, combinational.
- Tag push is visible at head one cycle after the start.
  - An rx_done in the start cycle itself pops an older entry only.
- owner updates at the edge after tx_command_started and holds through BUSY.
- The next offer is possible in the cycle after tx_done. This gives back-to-back issue with 1 idle cycle minimum.
- Reset mid-transaction: the FIFO and tags are discarded; later rx_done pulses raise err_unsolicited. Upstream reset is shared, so this is not expected.

## Test plan
- Single prefetch: p_cmd_valid=1 only. Expect tx_command=p_cmd and, on start, p_cmd_started=1 with d_cmd_started=0. Then 8 rx_data_valid strobes plus rx_done appear only on p_rx_*, and the FIFO returns to empty.
- Contention with STARVE_LIMIT=3: both requesters held valid continuously. Grant order must be D,D,D,P,D,D,D,P. starve_cnt is 0 after each P grant.
- Outstanding limit with MAX_OUTSTANDING=2: two reads issued with no rx_done. The third request sees tx_command_valid=0. After one rx_done, the offer reappears the next cycle.
- Ordering: issue a data read, then a prefetch read. The first rx burst goes to d_rx_*, the second to p_rx_*. A data write (d_expect_resp=0) issued between them pushes no tag and does not shift the steering.
- Simultaneous push/pop: a start with an expected response in the same cycle as rx_done, FIFO count 1. Count stays 1 and the head becomes the new tag.
- Unsolicited rx_done after reset: err_unsolicited=1 and stays set; no d_rx_* or p_rx_* output is asserted; reset clears the flag.

Source files
------------

// File: rtl/tx_bus_arbiter.sv
// tx_bus_arbiter
//   Shares one serial TX/RX memory channel between the data-access unit (d_*)
//   and the instruction prefetcher (p_*). It arbitrates command issue and
//   forwards the started pulse to the requester that was granted. A small tag
//   FIFO records the issue order of reads, and returning RX strobes are
//   steered to the requester that owns the oldest outstanding read.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   d_cmd_valid/d_cmd/d_expect_resp   data unit request, header, read flag
//   d_cmd_started                     data command accepted (combinational)
//   d_rx_data_valid/d_rx_done         RX strobe/completion for the data unit
//   p_cmd_valid/p_cmd                 prefetch request (always a read)
//   p_cmd_started                     prefetch command accepted
//   p_rx_data_valid/p_rx_done         RX strobe/completion for the prefetcher
//   tx_command_valid/tx_command       offer to the TX serializer
//   tx_command_started/tx_done        TX accept / transaction finished
//   rx_data_valid/rx_done             RX payload strobe / completion
//   owner                             0=data 1=prefetch, owner of current/last TX
//   err_unsolicited                   sticky: rx_done with nothing pending
module tx_bus_arbiter #(
   parameter int CMD_BITS        = 2,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                d_cmd_valid,
   input  logic [CMD_BITS-1:0] d_cmd,
   input  logic                d_expect_resp,
   output logic                d_cmd_started,
   output logic                d_rx_data_valid,
   output logic                d_rx_done,
   input  logic                p_cmd_valid,
   input  logic [CMD_BITS-1:0] p_cmd,
   output logic                p_cmd_started,
   output logic                p_rx_data_valid,
   output logic                p_rx_done,
   output logic                tx_command_valid,
   output logic [CMD_BITS-1:0] tx_command,
   input  logic                tx_command_started,
   input  logic                tx_done,
   input  logic                rx_data_valid,
   input  logic                rx_done,
   output logic                owner,
   output logic                err_unsolicited
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                     state_q, state_d;
   logic [SW-1:0]              starve_q;
   logic [CW-1:0]              count_q, count_d;
   // Tag FIFO kept as a shift register: entry 0 is always the head.
   logic [MAX_OUTSTANDING-1:0] tags_q, tags_d;

   logic sel_p, start, push, pop, empty, full, head;
   int   wr_idx;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(MAX_OUTSTANDING));
   assign head  = tags_q[0];

   // Prefetcher wins when data is absent or it has waited STARVE_LIMIT grants.
   assign sel_p            = !d_cmd_valid || (starve_q == SW'(STARVE_LIMIT));
   assign tx_command       = sel_p ? p_cmd : d_cmd;
   // A full FIFO blocks writes too, so issue order never needs reordering.
   assign tx_command_valid = (state_q == IDLE) && (d_cmd_valid || p_cmd_valid) && !full;
   assign start            = tx_command_valid && tx_command_started;
   assign d_cmd_started    = start && !sel_p;
   assign p_cmd_started    = start && sel_p;

   assign push = start && (sel_p || d_expect_resp);
   assign pop  = rx_done && !empty;

   assign d_rx_data_valid = rx_data_valid && !empty && !head;
   assign d_rx_done       = rx_done       && !empty && !head;
   assign p_rx_data_valid = rx_data_valid && !empty && head;
   assign p_rx_done       = rx_done       && !empty && head;

   // Next state. A start can only occur in IDLE, so a start coinciding with
   // tx_done always lands in BUSY.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)   state_d = BUSY;
         BUSY:    if (tx_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Tag FIFO next value. On a simultaneous pop the new tag lands one slot
   // lower because the existing entries shift down in the same cycle.
   always_comb begin
      tags_d  = tags_q;
      count_d = count_q;
      wr_idx  = pop ? int'(count_q) - 1 : int'(count_q);
      if (pop) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++)
            tags_d[i] = tags_q[i+1];
         tags_d[MAX_OUTSTANDING-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (i == wr_idx) tags_d[i] = sel_p;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         starve_q        <= '0;
         count_q         <= '0;
         tags_q          <= '0;
         owner           <= 1'b0;
         err_unsolicited <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tags_q  <= tags_d;
         if (start) begin
            owner <= sel_p;
            if (!sel_p && p_cmd_valid)
               starve_q <= (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
            else
               starve_q <= '0;
         end
         if (rx_done && empty) err_unsolicited <= 1'b1;
      end
   end

endmodule
